// File: rtl/issue_inst_queue_pkg.sv
// Shared types for the issue instruction queue: the decoded PC_set record
// and the default queue depth.
package issue_inst_queue_pkg;

    localparam int ISSUE_Q_DEPTH = 8;

    // One decoded instruction as handed from decode to issue
    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] inst;
    } PC_set;

    // Issue can never retire more than two entries; an encoding of 3 means 2
    function automatic logic [1:0] clamp_use(input logic [1:0] using_num);
        return (using_num == 2'd3) ? 2'd2 : using_num;
    endfunction

endpackage

// File: rtl/issue_inst_queue.sv
// Dual-ported decoupling FIFO between the dual decode stage and the issue
// stage. Up to two entries enter per cycle, the oldest two are always shown
// at the head, and issue retires 0/1/2 of them per cycle.
module issue_inst_queue
    import issue_inst_queue_pkg::*;
#(
    parameter int DEPTH = ISSUE_Q_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  PC_set       i_set1,
    input  PC_set       i_set2,
    input  logic [1:0]  i_is_valid,
    output logic        o_full,
    output PC_set       o_set1,
    output PC_set       o_set2,
    output logic [1:0]  o_is_valid,
    input  logic [1:0]  i_usingNUM
);

    localparam int PTR_W = $clog2(DEPTH);

    // Full means fewer than two free slots, so a dual push can always land
    localparam logic [PTR_W:0] FULL_LIMIT = (PTR_W + 1)'(DEPTH - 2);

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             can_push;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [1:0]       use_req;
    logic             we0;
    logic             we1;
    PC_set            wdata0;
    PC_set            wdata1;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;

    assign tail_p1 = tail + PTR_W'(1);
    assign head_p1 = head + PTR_W'(1);

    // Backpressure depends only on registered occupancy; same-cycle pops are
    // deliberately ignored to keep i_usingNUM off the o_full path
    assign o_full   = (count > FULL_LIMIT);
    assign can_push = !o_full && !i_flush;

    // Compact the incoming pair so valid entries land in consecutive slots
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        push_n = 2'd0;
        wdata0 = i_set1;
        wdata1 = i_set2;
        if (can_push) begin
            case (i_is_valid)
                2'b01: begin
                    we0    = 1'b1;
                    push_n = 2'd1;
                end
                2'b10: begin
                    we0    = 1'b1;
                    wdata0 = i_set2;
                    push_n = 2'd1;
                end
                2'b11: begin
                    we0    = 1'b1;
                    we1    = 1'b1;
                    push_n = 2'd2;
                end
                default: begin
                    push_n = 2'd0;
                end
            endcase
        end
    end

    // Retire no more entries than are actually queued
    always_comb begin
        use_req = clamp_use(i_usingNUM);
        pop_n   = use_req;
        if (count == '0) begin
            pop_n = 2'd0;
        end else if ((count == (PTR_W + 1)'(1)) && (use_req == 2'd2)) begin
            pop_n = 2'd1;
        end
    end

    // Entry storage; contents need no reset since validity lives in count
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[tail] <= wdata0;
        end
        if (we1) begin
            mem[tail_p1] <= wdata1;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + (PTR_W + 1)'(push_n) - (PTR_W + 1)'(pop_n);
        end
    end

    // Show-ahead view of the two oldest entries, zeroed when not valid
    always_comb begin
        o_is_valid = {(count >= (PTR_W + 1)'(2)), (count >= (PTR_W + 1)'(1))};
        o_set1     = o_is_valid[0] ? mem[head]    : '0;
        o_set2     = o_is_valid[1] ? mem[head_p1] : '0;
    end

endmodule

// File: tb/tb_issue_inst_queue.sv
// Randomised scoreboard bench for issue_inst_queue. A queue-based model of
// the FIFO produces the expected head view after every clock; a monitor
// compares it against the DUT on the following falling edge.
module tb_issue_inst_queue;
    import issue_inst_queue_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [1:0] valid;
        PC_set      set1;
        PC_set      set2;
        logic       full;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       i_flush;
    PC_set      i_set1;
    PC_set      i_set2;
    logic [1:0] i_is_valid;
    logic       o_full;
    PC_set      o_set1;
    PC_set      o_set2;
    logic [1:0] o_is_valid;
    logic [1:0] i_usingNUM;

    PC_set model_q[$];
    exp_t  exp_q[$];
    int    checks_total;
    int    checks_passed;

    issue_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_set1     (i_set1),
        .i_set2     (i_set2),
        .i_is_valid (i_is_valid),
        .o_full     (o_full),
        .o_set1     (o_set1),
        .o_set2     (o_set2),
        .o_is_valid (o_is_valid),
        .i_usingNUM (i_usingNUM)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        int   n;
        n       = model_q.size();
        e.valid = {(n >= 2), (n >= 1)};
        e.set1  = (n >= 1) ? model_q[0] : '0;
        e.set2  = (n >= 2) ? model_q[1] : '0;
        e.full  = (DEPTH - n) < 2;
        return e;
    endfunction

    // Drive one cycle of inputs, then advance the reference model across
    // the clock edge and queue the head view expected after it
    task automatic applyStimulus(input logic flush, input logic [1:0] valid,
                                 input PC_set s1, input PC_set s2,
                                 input logic [1:0] use_num);
        int    want;
        int    npop;
        bit    full_now;
        PC_set incoming[$];
        i_flush    = flush;
        i_is_valid = valid;
        i_set1     = s1;
        i_set2     = s2;
        i_usingNUM = use_num;
        full_now   = (DEPTH - model_q.size()) < 2;
        incoming   = {};
        if (valid[0]) incoming.push_back(s1);
        if (valid[1]) incoming.push_back(s2);
        @(posedge clk);
        if (flush) begin
            model_q = {};
        end else begin
            want = (use_num == 2'd3) ? 2 : int'(use_num);
            npop = (want < model_q.size()) ? want : model_q.size();
            repeat (npop) void'(model_q.pop_front());
            if (!full_now) begin
                foreach (incoming[k]) model_q.push_back(incoming[k]);
            end
        end
        exp_q.push_back(model_view());
        #1;
        i_flush    = 1'b0;
        i_is_valid = 2'b00;
        i_usingNUM = 2'd0;
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("o_is_valid", 64'(o_is_valid), 64'(e.valid));
            checkOutput("o_set1",     64'(o_set1),     64'(e.set1));
            checkOutput("o_set2",     64'(o_set2),     64'(e.set2));
            checkOutput("o_full",     64'(o_full),     64'(e.full));
        end
    end

    function automatic PC_set mk(input logic [31:0] pc);
        PC_set s;
        s.PC   = pc;
        s.inst = ~pc ^ 32'h0000_0013;
        return s;
    endfunction

    function automatic PC_set rnd_set();
        PC_set s;
        s.PC   = $urandom;
        s.inst = $urandom;
        return s;
    endfunction

    // Main stimulus sequence
    initial begin
        PC_set z;
        z            = '0;
        checks_total  = 0;
        checks_passed = 0;
        rst        = 1'b1;
        i_flush    = 1'b0;
        i_set1     = '0;
        i_set2     = '0;
        i_is_valid = 2'b00;
        i_usingNUM = 2'd0;

        // Reset state
        #12;
        checkOutput("reset o_is_valid", 64'(o_is_valid), 64'(2'b00));
        checkOutput("reset o_full",     64'(o_full),     64'(1'b0));
        checkOutput("reset o_set1",     64'(o_set1),     64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle, then single push followed by a single pop
        applyStimulus(1'b0, 2'b00, z, z, 2'd0);
        applyStimulus(1'b0, 2'b01, mk(32'h1c00_0000), z, 2'd0);
        applyStimulus(1'b0, 2'b00, z, z, 2'd1);

        // Fill to full, drop a fifth push, then pop two while still full
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b11, mk(32'h1c00_0000 + 32'(k * 8)),
                          mk(32'h1c00_0004 + 32'(k * 8)), 2'd0);
        end
        applyStimulus(1'b0, 2'b11, mk(32'hdead_0000), mk(32'hdead_0004), 2'd0);
        applyStimulus(1'b0, 2'b11, mk(32'hbeef_0000), mk(32'hbeef_0004), 2'd2);
        applyStimulus(1'b0, 2'b00, z, z, 2'd3);
        applyStimulus(1'b0, 2'b00, z, z, 2'd2);
        applyStimulus(1'b0, 2'b00, z, z, 2'd2);

        // Walk head to the last slot, then stream across the wrap point
        applyStimulus(1'b1, 2'b00, z, z, 2'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 2'b01, mk(32'h2000_0000 + 32'(k * 4)), z, 2'd1);
        end
        applyStimulus(1'b0, 2'b10, z, mk(32'h2000_0020), 2'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b00, z, z, 2'd1);
            applyStimulus(1'b0, 2'b11, mk(32'h2100_0000 + 32'(k * 8)),
                          mk(32'h2100_0004 + 32'(k * 8)), 2'd0);
        end
        repeat (6) applyStimulus(1'b0, 2'b00, z, z, 2'd1);
        applyStimulus(1'b0, 2'b00, z, z, 2'd2);
        applyStimulus(1'b0, 2'b00, z, z, 2'd2);

        // Flush with a concurrent push at count 5
        applyStimulus(1'b1, 2'b00, z, z, 2'd0);
        applyStimulus(1'b0, 2'b11, mk(32'h3000_0000), mk(32'h3000_0004), 2'd0);
        applyStimulus(1'b0, 2'b11, mk(32'h3000_0008), mk(32'h3000_000c), 2'd0);
        applyStimulus(1'b0, 2'b01, mk(32'h3000_0010), z, 2'd0);
        applyStimulus(1'b1, 2'b11, mk(32'h3f00_0000), mk(32'h3f00_0004), 2'd1);
        applyStimulus(1'b0, 2'b00, z, z, 2'd0);

        // Randomised traffic with occasional flushes
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 31) == 0), 2'($urandom),
                          rnd_set(), rnd_set(), 2'($urandom));
        end

        // Asynchronous reset between edges with three entries queued
        applyStimulus(1'b1, 2'b00, z, z, 2'd0);
        applyStimulus(1'b0, 2'b11, mk(32'h4000_0000), mk(32'h4000_0004), 2'd0);
        applyStimulus(1'b0, 2'b01, mk(32'h4000_0008), z, 2'd0);
        @(negedge clk);
        #2;
        checkOutput("pre-reset o_is_valid", 64'(o_is_valid), 64'(2'b11));
        rst = 1'b1;
        #1;
        checkOutput("async reset o_is_valid", 64'(o_is_valid), 64'(2'b00));
        checkOutput("async reset o_set1",     64'(o_set1),     64'(0));
        checkOutput("async reset o_full",     64'(o_full),     64'(1'b0));
        #1;
        rst = 1'b0;
        model_q = {};
        applyStimulus(1'b0, 2'b01, mk(32'h5000_0000), z, 2'd0);
        applyStimulus(1'b0, 2'b00, z, z, 2'd0);

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checkOutput("scoreboard drained", 64'(exp_q.size()), 64'(0));
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
